// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_pkg
// Description : Shared VGA timing constants and the 2-bit phase encoding used
//               by the horizontal and vertical phase counters.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

    // Default 640x480 @ 60 Hz segment lengths (pixels / lines)
    localparam int c_H_VISIBLE = 640;
    localparam int c_H_FRONT   = 16;
    localparam int c_H_SYNC    = 96;
    localparam int c_H_BACK    = 48;
    localparam int c_V_VISIBLE = 480;
    localparam int c_V_FRONT   = 10;
    localparam int c_V_SYNC    = 2;
    localparam int c_V_BACK    = 33;

    localparam int c_H_TOTAL = c_H_VISIBLE + c_H_FRONT + c_H_SYNC + c_H_BACK;
    localparam int c_V_TOTAL = c_V_VISIBLE + c_V_FRONT + c_V_SYNC + c_V_BACK;

    // Width of every position counter
    localparam int c_CNT_W = 10;

    // Phase encoding shared by both axes
    typedef logic [1:0] phase_t;
    localparam phase_t c_PH_VIS   = 2'd0;
    localparam phase_t c_PH_FRONT = 2'd1;
    localparam phase_t c_PH_SYNC  = 2'd2;
    localparam phase_t c_PH_BACK  = 2'd3;

endpackage : vga_timing_pkg
`default_nettype wire

// File: rtl/vga_phase_counter.sv
`default_nettype none
// ============================================================================
// Module      : vga_phase_counter
// Description : Position counter for one VGA axis together with its
//               VIS/FRONT/SYNC/BACK phase FSM. Counts 0..TOTAL-1 on i_adv.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_phase_counter
    import vga_timing_pkg::*;
#(
    parameter int VISIBLE = c_H_VISIBLE,
    parameter int FRONT   = c_H_FRONT,
    parameter int SYNC    = c_H_SYNC,
    parameter int BACK    = c_H_BACK
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_adv,
    output logic [c_CNT_W-1:0] o_cnt,
    output phase_t             o_phase
);

    localparam int c_TOTAL = VISIBLE + FRONT + SYNC + BACK;

    // Last count of each phase; the phase changes as the count leaves it
    localparam logic [c_CNT_W-1:0] c_VIS_END   = c_CNT_W'(VISIBLE - 1);
    localparam logic [c_CNT_W-1:0] c_FRONT_END = c_CNT_W'(VISIBLE + FRONT - 1);
    localparam logic [c_CNT_W-1:0] c_SYNC_END  = c_CNT_W'(VISIBLE + FRONT + SYNC - 1);
    localparam logic [c_CNT_W-1:0] c_LAST      = c_CNT_W'(c_TOTAL - 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    phase_t             r_phase;
    phase_t             w_phase_nxt;

    // Next count and next phase, both only moving when i_adv is high
    always_comb begin
        w_cnt_nxt   = r_cnt;
        w_phase_nxt = r_phase;
        if (i_adv) begin
            if (r_cnt == c_LAST) begin
                w_cnt_nxt = '0;
            end else begin
                w_cnt_nxt = r_cnt + 1'b1;
            end
            case (r_phase)
                c_PH_VIS:   if (r_cnt == c_VIS_END)   w_phase_nxt = c_PH_FRONT;
                c_PH_FRONT: if (r_cnt == c_FRONT_END) w_phase_nxt = c_PH_SYNC;
                c_PH_SYNC:  if (r_cnt == c_SYNC_END)  w_phase_nxt = c_PH_BACK;
                c_PH_BACK:  if (r_cnt == c_LAST)      w_phase_nxt = c_PH_VIS;
                default:    w_phase_nxt = c_PH_VIS;
            endcase
        end
    end

    // Count and phase state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_phase <= c_PH_VIS;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_phase <= w_phase_nxt;
        end
    end

    assign o_cnt   = r_cnt;
    assign o_phase = r_phase;

endmodule : vga_phase_counter
`default_nettype wire

// File: rtl/vga_sync_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_sync_gen
// Description : VGA sync generator. Derives a 25 MHz pixel clock/enable from
//               the 50 MHz clock, runs horizontal and vertical phase counters
//               and produces registered sync, visibility, coordinate and
//               end-of-visible-frame outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE = c_H_VISIBLE,
    parameter int H_FRONT   = c_H_FRONT,
    parameter int H_SYNC    = c_H_SYNC,
    parameter int H_BACK    = c_H_BACK,
    parameter int V_VISIBLE = c_V_VISIBLE,
    parameter int V_FRONT   = c_V_FRONT,
    parameter int V_SYNC    = c_V_SYNC,
    parameter int V_BACK    = c_V_BACK
) (
    input  logic               I_50MHZ_CLK,
    input  logic               I_RESET,
    output logic               vga_25clk,
    output logic               pix_en,
    output logic               O_HSYNC,
    output logic               O_VSYNC,
    output logic               display_data,
    output logic               draw_finish,
    output logic [c_CNT_W-1:0] O_PIX_X,
    output logic [c_CNT_W-1:0] O_PIX_Y
);

    localparam int c_H_TOT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam logic [c_CNT_W-1:0] c_H_LAST = c_CNT_W'(c_H_TOT - 1);
    localparam logic [c_CNT_W-1:0] c_V_VIS  = c_CNT_W'(V_VISIBLE);

    logic               r_vga_25clk;
    logic               r_pix_en;
    logic [c_CNT_W-1:0] w_h_cnt;
    logic [c_CNT_W-1:0] w_v_cnt;
    phase_t             w_h_phase;
    phase_t             w_v_phase;
    logic               w_h_wrap;
    logic               w_visible;

    logic               r_hsync;
    logic               r_vsync;
    logic               r_display;
    logic               r_draw_finish;
    logic [c_CNT_W-1:0] r_pix_x;
    logic [c_CNT_W-1:0] r_pix_y;

    // Divide-by-two pixel clock; pix_en mirrors it so it is high for the
    // clock cycle that starts with the 0->1 transition
    always_ff @(posedge I_50MHZ_CLK or posedge I_RESET) begin
        if (I_RESET) begin
            r_vga_25clk <= 1'b0;
            r_pix_en    <= 1'b0;
        end else begin
            r_vga_25clk <= ~r_vga_25clk;
            r_pix_en    <= ~r_vga_25clk;
        end
    end

    // The line counter wraps on the last pixel of a line; that tick advances
    // the frame counter so both wrap together at the end of the frame
    assign w_h_wrap  = r_pix_en && (w_h_cnt == c_H_LAST);
    assign w_visible = (w_h_phase == c_PH_VIS) && (w_v_phase == c_PH_VIS);

    vga_phase_counter #(
        .VISIBLE (H_VISIBLE),
        .FRONT   (H_FRONT),
        .SYNC    (H_SYNC),
        .BACK    (H_BACK)
    ) u_h_counter (
        .clk     (I_50MHZ_CLK),
        .rst     (I_RESET),
        .i_adv   (r_pix_en),
        .o_cnt   (w_h_cnt),
        .o_phase (w_h_phase)
    );

    vga_phase_counter #(
        .VISIBLE (V_VISIBLE),
        .FRONT   (V_FRONT),
        .SYNC    (V_SYNC),
        .BACK    (V_BACK)
    ) u_v_counter (
        .clk     (I_50MHZ_CLK),
        .rst     (I_RESET),
        .i_adv   (w_h_wrap),
        .o_cnt   (w_v_cnt),
        .o_phase (w_v_phase)
    );

    // Present the pixel the counters point at, updated once per pixel tick
    always_ff @(posedge I_50MHZ_CLK or posedge I_RESET) begin
        if (I_RESET) begin
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_display     <= 1'b0;
            r_draw_finish <= 1'b0;
            r_pix_x       <= '0;
            r_pix_y       <= '0;
        end else if (r_pix_en) begin
            r_hsync       <= (w_h_phase != c_PH_SYNC);
            r_vsync       <= (w_v_phase != c_PH_SYNC);
            r_display     <= w_visible;
            r_draw_finish <= (w_h_cnt == '0) && (w_v_cnt == c_V_VIS);
            r_pix_x       <= w_visible ? w_h_cnt : '0;
            r_pix_y       <= w_visible ? w_v_cnt : '0;
        end
    end

    assign vga_25clk    = r_vga_25clk;
    assign pix_en       = r_pix_en;
    assign O_HSYNC      = r_hsync;
    assign O_VSYNC      = r_vsync;
    assign display_data = r_display;
    assign draw_finish  = r_draw_finish;
    assign O_PIX_X      = r_pix_x;
    assign O_PIX_Y      = r_pix_y;

endmodule : vga_sync_gen
`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_sync_gen
// Description : Self-checking bench for vga_sync_gen. Runs a default-timing
//               instance and a reduced-timing instance side by side against
//               an arithmetic reference model fed through scoreboard queues.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_sync_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    // Default-timing instance
    logic       d_vga, d_pix, d_hs, d_vs, d_disp, d_df;
    logic [9:0] d_x, d_y;
    logic [23:0] d_vec;
    assign d_vec = {d_hs, d_vs, d_disp, d_df, d_x, d_y};

    // Reduced-timing instance (H 8/2/2/2, V 4/1/1/1)
    logic       s_vga, s_pix, s_hs, s_vs, s_disp, s_df;
    logic [9:0] s_x, s_y;
    logic [23:0] s_vec;
    assign s_vec = {s_hs, s_vs, s_disp, s_df, s_x, s_y};

    vga_sync_gen u_def (
        .I_50MHZ_CLK  (clk),
        .I_RESET      (rst),
        .vga_25clk    (d_vga),
        .pix_en       (d_pix),
        .O_HSYNC      (d_hs),
        .O_VSYNC      (d_vs),
        .display_data (d_disp),
        .draw_finish  (d_df),
        .O_PIX_X      (d_x),
        .O_PIX_Y      (d_y)
    );

    vga_sync_gen #(
        .H_VISIBLE (8), .H_FRONT (2), .H_SYNC (2), .H_BACK (2),
        .V_VISIBLE (4), .V_FRONT (1), .V_SYNC (1), .V_BACK (1)
    ) u_sml (
        .I_50MHZ_CLK  (clk),
        .I_RESET      (rst),
        .vga_25clk    (s_vga),
        .pix_en       (s_pix),
        .O_HSYNC      (s_hs),
        .O_VSYNC      (s_vs),
        .display_data (s_disp),
        .draw_finish  (s_df),
        .O_PIX_X      (s_x),
        .O_PIX_Y      (s_y)
    );

    localparam logic [23:0] c_RST_VEC = {1'b1, 1'b1, 1'b0, 1'b0, 10'd0, 10'd0};

    int n_checks = 0;
    int n_errors = 0;

    logic [23:0] q_def[$];
    logic [23:0] q_sml[$];

    // Aggregate counters (clock cycles with the output in the given state)
    int cnt_s_disp, cnt_s_df, cnt_s_hs, cnt_s_vs;
    int cnt_d_disp, cnt_d_hs;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected output vector for the k-th presented pixel after reset
    function automatic logic [23:0] exp_out(input int k,
                                            input int hv, input int hf, input int hs, input int hb,
                                            input int vv, input int vf, input int vs, input int vb);
        int ht = hv + hf + hs + hb;
        int vt = vv + vf + vs + vb;
        int h  = k % ht;
        int v  = (k / ht) % vt;
        logic e_hs  = !((h >= hv + hf) && (h < hv + hf + hs));
        logic e_vs  = !((v >= vv + vf) && (v < vv + vf + vs));
        logic e_vis = (h < hv) && (v < vv);
        logic e_df  = (h == 0) && (v == vv);
        logic [9:0] e_x = e_vis ? 10'(h) : 10'd0;
        logic [9:0] e_y = e_vis ? 10'(v) : 10'd0;
        return {e_hs, e_vs, e_vis, e_df, e_x, e_y};
    endfunction

    // Monitor: n counts rising edges since reset release. A pix_en cycle
    // (odd n) pushes the pixel the next update must present; the following
    // sample (even n) pops and compares it.
    initial begin
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                n = 0;
                q_def.delete();
                q_sml.delete();
                check("def_rst_vec", {6'd0, d_vga, d_pix, d_vec}, {8'd0, c_RST_VEC});
                check("sml_rst_vec", {6'd0, s_vga, s_pix, s_vec}, {8'd0, c_RST_VEC});
            end else begin
                n++;
                check("def_clk_en", {d_vga, d_pix}, {n[0], n[0]});
                check("sml_clk_en", {s_vga, s_pix}, {n[0], n[0]});
                if (n % 2 == 1) begin
                    q_def.push_back(exp_out((n - 1) / 2, 640, 16, 96, 48, 480, 10, 2, 33));
                    q_sml.push_back(exp_out((n - 1) / 2, 8, 2, 2, 2, 4, 1, 1, 1));
                end else begin
                    if (q_def.size() > 0) check("def_pixel", d_vec, q_def.pop_front());
                    else                  check("def_queue_underflow", 1, 0);
                    if (q_sml.size() > 0) check("sml_pixel", s_vec, q_sml.pop_front());
                    else                  check("sml_queue_underflow", 1, 0);
                end
                if (s_disp) cnt_s_disp++;
                if (s_df)   cnt_s_df++;
                if (!s_hs)  cnt_s_hs++;
                if (!s_vs)  cnt_s_vs++;
                if (d_disp) cnt_d_disp++;
                if (!d_hs)  cnt_d_hs++;
                check("df_disp_overlap", {d_df & d_disp, s_df & s_disp}, 2'b00);
            end
        end
    end

    // Directed sequence
    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_def_pix_en", {d_vga, d_pix}, 2'b00);
        check("rst_sml_sync", {s_hs, s_vs, s_disp, s_df}, 4'b1100);

        // Release reset mid low phase, then check the first presented pixel
        @(negedge clk);
        #2 rst = 1'b0;
        cnt_s_disp = 0; cnt_s_df = 0; cnt_s_hs = 0; cnt_s_vs = 0;
        cnt_d_disp = 0; cnt_d_hs = 0;
        repeat (2) @(negedge clk);
        #1;
        check("first_pixel_sml", {s_disp, s_x, s_y}, {1'b1, 10'd0, 10'd0});
        check("first_pixel_def", {d_disp, d_x, d_y}, {1'b1, 10'd0, 10'd0});

        // Two full reduced frames: 196 ticks
        repeat (390) @(negedge clk);
        #1;
        check("sml_disp_clocks_2frames", cnt_s_disp, 128);
        check("sml_draw_finish_clocks",  cnt_s_df,   4);
        check("sml_hsync_low_clocks",    cnt_s_hs,   56);
        check("sml_vsync_low_clocks",    cnt_s_vs,   56);

        // Two default lines: 1600 ticks plus the first half of the next pixel
        repeat (2810) @(negedge clk);
        #1;
        check("def_hsync_low_clocks_2lines", cnt_d_hs,   384);
        check("def_disp_clocks_2lines",      cnt_d_disp, 2561);

        // Reset in the middle of the reduced frame; outputs clear at once
        repeat (30) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_def_vec", {6'd0, d_vga, d_pix, d_vec}, {8'd0, c_RST_VEC});
        check("midrst_sml_vec", {6'd0, s_vga, s_pix, s_vec}, {8'd0, c_RST_VEC});
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        cnt_s_disp = 0; cnt_s_df = 0; cnt_s_hs = 0; cnt_s_vs = 0;
        cnt_d_disp = 0; cnt_d_hs = 0;

        // Earliest possible draw_finish of the new frame is at its line 4
        repeat (100) @(negedge clk);
        #1;
        check("post_rst_no_early_df", cnt_s_df, 0);
        repeat (96) @(negedge clk);
        #1;
        check("post_rst_df_clocks",   cnt_s_df,   2);
        check("post_rst_disp_clocks", cnt_s_disp, 64);
        check("post_rst_vsync_clocks", cnt_s_vs,  28);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_vga_sync_gen
`default_nettype wire
